vga_screen_scanner: RTL and testbench
=====================================

Name: vga_screen_scanner

Overview:
- Parametrised raster scanner and screen selector for the 160x120 vga_adapter path.
- Sweeps the framebuffer coordinates and issues ROM addresses to NUM_SCREENS background ROMs (one shared address, 1-cycle synchronous ROMs).
- Chooses the active screen from a prioritised request vector, with optional two-frame animation per screen.
- Outputs pipeline-aligned x/y/colour/plot to the adapter. Screen changes take effect only at frame boundaries, so there is no mid-frame tearing.

Parameters:
- H_RES, 160: pixels per line.
- V_RES, 120: lines per frame.
- X_W, 8: x width; must satisfy 2^X_W >= H_RES.
- Y_W, 7: y width; must satisfy 2^Y_W >= V_RES.
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- NUM_SCREENS, 8: number of ROM images. Screen 0 is the default/menu screen.
- SEL_W, 3: screen index width; must satisfy 2^SEL_W >= NUM_SCREENS.
- COLOUR_W, 3: bits per pixel.
- ROM_LATENCY, 1: ROM read latency in cycles (1..3).
- ANIM_PERIOD, 5000000: clock cycles per animation phase.
- ANIM_MASK, 8'b0000_0010: bit s set means screen s animates and alternates with screen s+1.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- req, in, NUM_SCREENS-1: screen requests. Bit i requests screen i+1; lower i has higher priority.
- mem_address, out, ADDR_W: shared ROM address.
- rom_colour, in, NUM_SCREENS*COLOUR_W: ROM data. Screen s occupies bits [s*COLOUR_W +: COLOUR_W].
- x, out, X_W: pixel x, aligned with colour.
- y, out, Y_W: pixel y, aligned with colour.
- colour, out, COLOUR_W: pixel colour.
- plot, out, 1: pixel write enable.
- active_screen, out, SEL_W: screen index used for the current frame.
- anim_phase, out, 1: current animation phase.
- frame_start, out, 1: one-cycle pulse when the first pixel of a frame is output.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: mem_address=0, x=0, y=0, colour=0, plot=0, active_screen=0, anim_phase=0, frame_start=0.
  - Internal state: scan counters and pipeline valid bits are cleared.
  - A reset mid-frame discards in-flight pixels, and scanning restarts at (0,0).
- Scan counters (sx, sy):
  - sx increments every cycle; at H_RES-1 it wraps to 0 and sy increments.
  - sy wraps to 0 after V_RES-1.
  - No out-of-range coordinate (sx=H_RES or sy=V_RES) is ever produced.
- Address:
  - mem_address is registered: mem_address = sy*H_RES + sx, one cycle after the counter value.
  - Computation is done at ADDR_W width with no truncation for legal parameters.
- Screen selection:
  - Combinational candidate: the highest-priority set bit of req gives base = i+1; if req is all zero, base = 0.
  - If ANIM_MASK[base] is set and anim_phase=1, the candidate is base+1; otherwise it is base.
  - active_screen loads the candidate only in the cycle the counters issue (0,0). It is held for the rest of the frame.
- Animation:
  - A counter runs from 0 to ANIM_PERIOD-1; anim_phase toggles when it wraps.
  - The counter is free-running and independent of the scan.
  - Because of the frame-boundary latch, a phase change becomes visible at the next frame.
- Pipeline:
  - Coordinates and active_screen are delayed by L = 1 + ROM_LATENCY stages.
  - colour is registered as the rom_colour slice of the delayed screen.
  - x, y, colour, and plot appear together, L+1 cycles after the counter issues the coordinate.
  - plot=1 only for pipeline stages that hold valid pixels. It is 0 for the first L+1 cycles after reset, then 1 continuously.
- frame_start is 1 exactly when the output pixel is (0,0) with plot=1.
- Simultaneous events:
  - A req change during a frame is ignored until the next (0,0).
  - A req change and an anim_phase toggle in the same cycle as (0,0) are both honoured, using the values sampled that cycle.

Decomposition:
- Package vga_scan_pkg holds:
  - default resolution constants;
  - the screen-index constants SCR_MENU=0, SCR_ABOUT=1, SCR_MANUAL=2, SCR_DISPENSER=3, SCR_TIMESET=4, SCR_DISP_A=5, SCR_DISP_B=6, SCR_LOWMEDS=7;
  - the priority-order note for req.
- Sub-module anim_toggler(clock, reset, phase), parametrised by ANIM_PERIOD. It replaces the old animation divider.

Test Plan:
- Reset release, ROM model rom[s][a] = (a+s) mod 8 with ROM_LATENCY=1:
  - first plot=1 occurs at cycle 3 with x=0, y=0, colour=0, frame_start=1;
  - x=159, y=0 follows at cycle 162;
  - x=0, y=1 follows at cycle 163 with colour=160 mod 8 = 0.
- Full frame: plot stays high; frame_start pulses exactly every 19200 cycles; mem_address runs 0..19199 then wraps to 0.
- req=7'b0000100 raised mid-frame:
  - active_screen stays 0 until the next (0,0), then becomes 3;
  - colour equals the screen-3 ROM data for all pixels of that frame.
- req=7'b1000001, priority: active_screen=1. Then req=0 gives active_screen=0 at the next frame.
- Animation with ANIM_PERIOD=100 and req bit 0 set (screen 1 in ANIM_MASK): active_screen alternates 1/2 on frames whose (0,0) sample falls in phase 0/1.
- Reset asserted mid-frame at pixel (80,60): all outputs are 0 immediately; after release, the sequence restarts at (0,0) with the L+1 cycle plot gap.

Source files
------------

// File: rtl/vga_screen_scanner_pkg.sv
// vga_scan_pkg: shared resolution defaults and screen indices for the 160x120 scanner.
// req priority: bit i requests screen i+1 and the lowest set bit wins; no request selects SCR_MENU.
package vga_scan_pkg;
    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;
    localparam int X_W_DEF = 8;
    localparam int Y_W_DEF = 7;
    localparam int ADDR_W_DEF = 15;
    localparam int NUM_SCREENS_DEF = 8;
    localparam int SEL_W_DEF = 3;
    localparam int COLOUR_W_DEF = 3;

    typedef enum logic [2:0] {
        SCR_MENU      = 3'd0,
        SCR_ABOUT     = 3'd1,
        SCR_MANUAL    = 3'd2,
        SCR_DISPENSER = 3'd3,
        SCR_TIMESET   = 3'd4,
        SCR_DISP_A    = 3'd5,
        SCR_DISP_B    = 3'd6,
        SCR_LOWMEDS   = 3'd7
    } screen_e;
endpackage

// File: rtl/vga_screen_scanner_if.sv
// vga_screen_scanner_if: request/ROM/pixel bundle between the scanner (master) and its surroundings (slave).
interface vga_screen_scanner_if
    import vga_scan_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_SCREENS = NUM_SCREENS_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
);
    logic [NUM_SCREENS-2:0] req;
    logic [ADDR_W-1:0] mem_address;
    logic [NUM_SCREENS*COLOUR_W-1:0] rom_colour;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [COLOUR_W-1:0] colour;
    logic plot;
    logic [SEL_W-1:0] active_screen;
    logic anim_phase;
    logic frame_start;

    modport master (
        input req, rom_colour,
        output mem_address, x, y, colour, plot, active_screen, anim_phase, frame_start
    );
    modport slave (
        output req, rom_colour,
        input mem_address, x, y, colour, plot, active_screen, anim_phase, frame_start
    );
endinterface

// File: rtl/vga_screen_scanner_anim_toggler.sv
// anim_toggler: free-running divider; phase flips each time the counter wraps after ANIM_PERIOD cycles.
module anim_toggler #(
    parameter int ANIM_PERIOD = 5000000
) (
    input  logic clock,
    input  logic reset,
    output logic phase
);
    localparam int CW = $clog2(ANIM_PERIOD > 1 ? ANIM_PERIOD : 2);

    logic [CW-1:0] r_cnt;
    logic w_wrap;

    assign w_wrap = (r_cnt == CW'(ANIM_PERIOD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            phase <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            phase <= w_wrap ? ~phase : phase;
        end
    end
endmodule

// File: rtl/vga_screen_scanner.sv
// vga_screen_scanner: raster sweep, shared ROM addressing and frame-latched screen selection.
module vga_screen_scanner
    import vga_scan_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_SCREENS = NUM_SCREENS_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF,
    parameter int ROM_LATENCY = 1,
    parameter int ANIM_PERIOD = 5000000,
    parameter logic [NUM_SCREENS-1:0] ANIM_MASK = 8'b0000_0010
) (
    input logic clock,
    input logic reset,
    vga_screen_scanner_if.master bus
);
    localparam int L = 1 + ROM_LATENCY;

    logic [X_W-1:0] r_sx;
    logic [Y_W-1:0] r_sy;
    logic [X_W-1:0] r_px [1:L];
    logic [Y_W-1:0] r_py [1:L];
    logic [SEL_W-1:0] r_ps [1:L];
    logic [L:1] r_pv;
    logic [SEL_W-1:0] r_active;
    logic [SEL_W-1:0] w_base;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_scr;
    logic w_phase;
    logic w_first;
    logic w_eol;

    anim_toggler #(.ANIM_PERIOD(ANIM_PERIOD)) u_anim (
        .clock(clock),
        .reset(reset),
        .phase(w_phase)
    );

    // Scanning downward gives the lowest set request bit the final say.
    always_comb begin
        w_base = '0;
        for (int i = NUM_SCREENS - 2; i >= 0; i--)
            if (bus.req[i]) w_base = SEL_W'(i + 1);
        w_cand = (ANIM_MASK[w_base] && w_phase) ? w_base + SEL_W'(1) : w_base;
    end

    assign w_first = (r_sx == '0) && (r_sy == '0);
    assign w_eol = (r_sx == X_W'(H_RES - 1));
    assign w_scr = w_first ? w_cand : r_active;
    assign bus.active_screen = r_active;
    assign bus.anim_phase = w_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sx <= '0;
            r_sy <= '0;
            r_active <= SEL_W'(SCR_MENU);
            r_pv <= '0;
            for (int k = 1; k <= L; k++) begin
                r_px[k] <= '0;
                r_py[k] <= '0;
                r_ps[k] <= '0;
            end
            bus.mem_address <= '0;
            bus.x <= '0;
            bus.y <= '0;
            bus.colour <= '0;
            bus.plot <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            r_sx <= w_eol ? '0 : r_sx + X_W'(1);
            r_sy <= !w_eol ? r_sy : (r_sy == Y_W'(V_RES - 1)) ? '0 : r_sy + Y_W'(1);
            r_active <= w_scr;
            bus.mem_address <= ADDR_W'(r_sy) * ADDR_W'(H_RES) + ADDR_W'(r_sx);
            // Stage L lines up with the ROM word addressed by that coordinate.
            r_px[1] <= r_sx;
            r_py[1] <= r_sy;
            r_ps[1] <= w_scr;
            r_pv <= {r_pv[L-1:1], 1'b1};
            for (int k = 2; k <= L; k++) begin
                r_px[k] <= r_px[k-1];
                r_py[k] <= r_py[k-1];
                r_ps[k] <= r_ps[k-1];
            end
            bus.x <= r_px[L];
            bus.y <= r_py[L];
            bus.colour <= bus.rom_colour[r_ps[L]*COLOUR_W +: COLOUR_W];
            bus.plot <= r_pv[L];
            bus.frame_start <= r_pv[L] && (r_px[L] == '0) && (r_py[L] == '0);
        end
    end
endmodule

// File: tb/tb_vga_screen_scanner.sv
// tb_vga_screen_scanner: directed checks of scan timing, ROM alignment, screen latching, animation and reset.
module tb_vga_screen_scanner;
    localparam int FRAME = 19200;
    localparam int C_END = 3 * FRAME + 3 + 9680;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errors = 0;
    int scr [4] = '{0, 3, 1, 0};

    always #5 clk = ~clk;

    vga_screen_scanner_if m ();
    vga_screen_scanner_if a ();

    vga_screen_scanner #(.ANIM_PERIOD(5000000)) dut (
        .clock(clk),
        .reset(rst),
        .bus(m.master)
    );

    vga_screen_scanner #(.H_RES(10), .V_RES(10), .ANIM_PERIOD(100)) dut_a (
        .clock(clk),
        .reset(rst),
        .bus(a.master)
    );

    // Synchronous ROMs: screen s holds (address + s) mod 8.
    always @(posedge clk)
        for (int s = 0; s < 8; s++)
            m.rom_colour[s*3 +: 3] <= 3'(m.mem_address + 15'(s));

    assign a.rom_colour = '0;
    assign a.req = 7'b0000001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_address"}, 32'(m.mem_address), 0);
        chk({tag, " x"}, 32'(m.x), 0);
        chk({tag, " y"}, 32'(m.y), 0);
        chk({tag, " colour"}, 32'(m.colour), 0);
        chk({tag, " plot"}, 32'(m.plot), 0);
        chk({tag, " active_screen"}, 32'(m.active_screen), 0);
        chk({tag, " anim_phase"}, 32'(m.anim_phase), 0);
        chk({tag, " frame_start"}, 32'(m.frame_start), 0);
    endtask

    initial begin
        m.req = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        chk("c0 plot", 32'(m.plot), 0);
        for (int c = 1; c <= C_END; c++) begin
            @(negedge clk);
            chk("mem_address", 32'(m.mem_address), (c - 1) % FRAME);
            chk("active_screen", 32'(m.active_screen), scr[(c - 1) / FRAME]);
            if (c < 3) begin
                chk("early plot", 32'(m.plot), 0);
                chk("early frame_start", 32'(m.frame_start), 0);
            end else begin
                int p, s;
                p = (c - 3) % FRAME;
                s = scr[(c - 3) / FRAME];
                chk("plot", 32'(m.plot), 1);
                chk("x", 32'(m.x), p % 160);
                chk("y", 32'(m.y), p / 160);
                chk("colour", 32'(m.colour), (p + s) % 8);
                chk("frame_start", 32'(m.frame_start), (p == 0) ? 1 : 0);
            end
            if (c < 600 && c % 100 == 50) begin
                chk("anim active_screen", 32'(a.active_screen), ((c / 100) % 2 == 1) ? 2 : 1);
                chk("anim phase", 32'(a.anim_phase), (c / 100) % 2);
            end
            if (c == 9600) m.req = 7'b0000100;
            if (c == FRAME + 9600) m.req = 7'b1000001;
            if (c == 2 * FRAME + 9600) m.req = 7'b0000000;
        end
        #2;
        rst = 1'b1;
        #1;
        chk_zero("mid reset");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("restart mem_address", 32'(m.mem_address), c - 1);
            chk("restart plot", 32'(m.plot), (c == 3) ? 1 : 0);
            chk("restart frame_start", 32'(m.frame_start), (c == 3) ? 1 : 0);
            chk("restart x", 32'(m.x), 0);
            chk("restart y", 32'(m.y), 0);
            chk("restart active_screen", 32'(m.active_screen), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
